// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default frame geometry and
// parity-sense constants. Used by uart_rx now and by uart_tx once it gains
// parity support.
package uart_pkg;

  // Default frame geometry.
  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_BITS_DEF  = 8;

  // Raw 3-bit state encodings, kept as plain localparams so that other
  // blocks and checkers can compare against them without the enum type.
  localparam logic [2:0] UART_ST_IDLE   = 3'd0;
  localparam logic [2:0] UART_ST_START  = 3'd1;
  localparam logic [2:0] UART_ST_DATA   = 3'd2;
  localparam logic [2:0] UART_ST_PARITY = 3'd3;
  localparam logic [2:0] UART_ST_STOP   = 3'd4;
  localparam logic [2:0] UART_ST_BREAK  = 3'd5;

  // Parity sense: even means the parity bit equals the XOR of the data bits.
  localparam bit UART_PARITY_EVEN = 1'b0;
  localparam bit UART_PARITY_ODD  = 1'b1;

  // Receiver state type built on the shared encodings.
  typedef enum logic [2:0] {
    ST_IDLE   = UART_ST_IDLE,
    ST_START  = UART_ST_START,
    ST_DATA   = UART_ST_DATA,
    ST_PARITY = UART_ST_PARITY,
    ST_STOP   = UART_ST_STOP,
    ST_BREAK  = UART_ST_BREAK
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input. Both flops reset to
// RESET_VAL so that an idle-high line does not look like an edge coming out
// of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the asynchronous input, then give it a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises start / DATA_BITS data (LSB first) / [parity] /
// stop frames from an oversampled asynchronous line and hands each byte to a
// valid/ready consumer. Reports framing and overrun errors.
//
// Optional build macro UART_RX_PARITY_EN: adds a parity bit between the data
// and stop bits, the PARITY_ODD parameter and the parity_err output.
//
// Handshake: rx_valid rises when a byte is delivered and rx_data is frozen
// while rx_valid is high. A transfer happens on every clk edge where
// rx_valid && rx_ready; rx_valid then drops on the next clk unless a new byte
// is delivered on that very edge, in which case the new byte replaces the
// accepted one and rx_valid stays high. A byte completing while rx_valid is
// high and rx_ready is low is dropped and flagged by overrun_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int DATA_BITS  = UART_DATA_BITS_DEF
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = UART_PARITY_EVEN
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 sample_tick,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Sample points inside a bit period. The start bit is checked half a bit
  // after the detected edge; from then on every bit is sampled one full
  // period later, which lands each sample in the middle of its bit.
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_e       state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 deliver;
  logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_n;
`endif

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // FSM and datapath registers; they only move on sample_tick clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
`ifdef UART_RX_PARITY_EN
      par_bad   <= par_bad_n;
`endif
    end
  end

  // Next-state logic; also raises the one-clk deliver / stop_bad strobes on
  // the tick that samples the stop bit.
  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    bit_n     = bit_cnt;
    shift_n   = shift_reg;
    deliver   = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
`endif
    if (sample_tick) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_n = ST_START;
            tick_n  = '0;
          end
        end

        ST_START: begin
          if (tick_cnt == TICK_MID) begin
            tick_n = '0;
            if (rx_s) begin
              // Line went back high before mid-bit: a glitch, not a frame.
              state_n = ST_IDLE;
            end else begin
              state_n = ST_DATA;
              bit_n   = '0;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_n    = '0;
            par_bad_n = (rx_s != ((^shift_reg) ^ PARITY_ODD));
            state_n   = ST_STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_n = '0;
            if (rx_s) begin
              deliver = 1'b1;
              state_n = ST_IDLE;
            end else begin
              stop_bad = 1'b1;
              state_n  = ST_BREAK;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end

        ST_BREAK: begin
          // Stay here while the line is held low so a break never turns
          // into a stream of bogus frames.
          if (rx_s) begin
            state_n = ST_IDLE;
          end
        end

        default: begin
          state_n = ST_IDLE;
          tick_n  = '0;
        end
      endcase
    end
  end

  // Busy covers every state that is in the middle of a frame.
  always_comb begin
    rx_busy = (state == ST_START) || (state == ST_DATA) ||
              (state == ST_PARITY) || (state == ST_STOP);
  end

  // Output handshake and error pulses, evaluated on every clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err <= par_bad;
`endif
        end else begin
          // Consumer still holds the previous byte: drop the new one.
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
    end
  end

endmodule
